serdesphy_tx_lane: RTL and testbench

Parametrised transmit lane for the SerDes PHY: accepts parallel words on a valid/ready handshake, buffers them in a small FIFO, and serialises them MSB-first onto the txp/txn differential pair. Generalises the fixed 4-bit TX path of the current PHY top in word width and buffer depth. Adds a sync preamble, fill insertion on starvation, overflow reporting, and an optional PRBS-7 test source. Sits between the top-level TX pins and the pad drivers, clocked by the reference clock as the bit clock.

---
 rtl/serdesphy_pkg.sv | 29 ++
 rtl/serdesphy_sync_fifo.sv | 47 ++++
 rtl/serdesphy_tx_lane.sv | 161 ++++++++++++++++
 tb/tb_serdesphy_tx_lane.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_pkg.sv
// Shared types and constants for the SerDes PHY transmit lane: lane states,
// word-source selection, the PRBS-7 polynomial and the default sync word.
package serdesphy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA
    } lane_state_t;

    typedef enum logic [1:0] {
        SRC_SYNC,
        SRC_PRBS,
        SRC_FIFO,
        SRC_FILL
    } word_src_t;

    // x^7 + x^6 + 1: feedback from bits 6 and 5, serial output is bit 6
    localparam int         PRBS7_TAP_HI = 6;
    localparam int         PRBS7_TAP_LO = 5;
    localparam logic [6:0] PRBS7_SEED   = 7'h7F;

    localparam logic [3:0] SYNC_WORD_DEFAULT = 4'hA;

    function automatic logic [6:0] prbs7_next(input logic [6:0] r);
        return {r[5:0], r[PRBS7_TAP_HI] ^ r[PRBS7_TAP_LO]};
    endfunction

endpackage

// File: rtl/serdesphy_sync_fifo.sv
// Single-clock word FIFO with occupancy level; full blocks writes regardless of
// a same-cycle read, and the head entry is presented combinationally.
module serdesphy_sync_fifo #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             head,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/serdesphy_tx_lane.sv
// SerDes TX lane: FIFO-buffered words serialised MSB-first with sync preamble and
// fill on starvation. Define SERDESPHY_PRBS_EN to build the PRBS-7 test source.
module serdesphy_tx_lane
    import serdesphy_pkg::*;
#(
    parameter int                DATA_W     = 4,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD  = DATA_W'(SYNC_WORD_DEFAULT),
    parameter int                SYNC_REPS  = 4
) (
    input  logic                          clk_ref_24m,
    input  logic                          rst_n,
    input  logic                          tx_en,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          prbs_mode,
    input  logic                          clr_err,
    output logic                          txp,
    output logic                          txn,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          busy
);
    localparam int                CNT_W     = $clog2(DATA_W);
    localparam int                SCNT_W    = $clog2(SYNC_REPS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [SCNT_W-1:0] LAST_SYNC = SCNT_W'(SYNC_REPS - 1);

    lane_state_t       state, state_nx;
    word_src_t         src, data_src;
    logic              load;
    logic              boundary;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              serial_bit;
    logic [CNT_W-1:0]  bit_cnt;
    logic [SCNT_W-1:0] sync_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] fifo_head;
    logic [DATA_W-1:0] next_word;

    serdesphy_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_ref_24m),
        .rst_n   (rst_n),
        .push    (tx_valid),
        .wr_data (tx_data),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign tx_ready  = !fifo_full;
    assign txn       = ~txp;
    assign busy      = (state != IDLE);
    assign boundary  = (bit_cnt == LAST_BIT);
    assign fifo_pop  = load && (src == SRC_FIFO);
    assign next_word = (src == SRC_FIFO) ? fifo_head : SYNC_WORD;

`ifdef SERDESPHY_PRBS_EN
    logic [6:0] prbs;
    logic       prbs_word;

    assign data_src   = prbs_mode  ? SRC_PRBS :
                        fifo_empty ? SRC_FILL : SRC_FIFO;
    assign serial_bit = prbs_word ? prbs[PRBS7_TAP_HI] : shreg[DATA_W-1];

    // The generator only steps while its bits are actually on the line
    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            prbs      <= PRBS7_SEED;
            prbs_word <= 1'b0;
        end else begin
            if (state == IDLE || boundary) prbs_word <= load && (src == SRC_PRBS);
            if (prbs_word) prbs <= prbs7_next(prbs);
        end
    end
`else
    logic unused_prbs_mode;

    assign unused_prbs_mode = prbs_mode;
    assign data_src         = fifo_empty ? SRC_FILL : SRC_FIFO;
    assign serial_bit       = shreg[DATA_W-1];
`endif

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        src      = SRC_FILL;
        case (state)
            IDLE: begin
                if (tx_en) begin
                    state_nx = SYNC;
                    load     = 1'b1;
                    src      = SRC_SYNC;
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (!tx_en) begin
                        state_nx = IDLE;
                    end else if (sync_cnt != LAST_SYNC) begin
                        load = 1'b1;
                        src  = SRC_SYNC;
                    end else begin
                        state_nx = DATA;
                        load     = 1'b1;
                        src      = data_src;
                    end
                end
            end
            DATA: begin
                if (boundary) begin
                    if (!tx_en) begin
                        state_nx = IDLE;
                    end else begin
                        load = 1'b1;
                        src  = data_src;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            sync_cnt <= '0;
            txp      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                bit_cnt  <= '0;
                sync_cnt <= '0;
                txp      <= 1'b0;
            end else begin
                bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;
                txp     <= serial_bit;
                if (state == SYNC && boundary) sync_cnt <= sync_cnt + 1'b1;
            end
            // A new overflow event outranks a simultaneous clear
            if (tx_valid && !tx_ready) overflow <= 1'b1;
            else if (clr_err)          overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_ref_24m) begin
        if (load) shreg <= next_word;
        else      shreg <= shreg << 1;
    end

endmodule

// File: tb/tb_serdesphy_tx_lane.sv
// Scoreboard bench for serdesphy_tx_lane: expected serial bits are queued as stimulus
// is driven and popped by a monitor sampling txp/txn shortly after each rising edge.
`timescale 1ns/1ps
module tb_serdesphy_tx_lane;
    localparam int         DATA_W     = 4;
    localparam int         FIFO_DEPTH = 8;
    localparam logic [3:0] SYNC_W     = 4'hA;
    localparam logic [3:0] FILL_W     = 4'hA;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b0;
    logic [3:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       prbs_mode = 1'b0;
    logic       clr_err = 1'b0;
    logic       txp;
    logic       txn;
    logic [3:0] fifo_level;
    logic       overflow;
    logic       busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_q[$];
    logic mon_en = 1'b0;
    int   bit_idx = 0;
    int   cyc = 0;
    int   base = 0;

    serdesphy_tx_lane #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SYNC_WORD  (SYNC_W),
        .SYNC_REPS  (4)
    ) dut (
        .clk_ref_24m (clk),
        .rst_n       (rst_n),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .prbs_mode   (prbs_mode),
        .clr_err     (clr_err),
        .txp         (txp),
        .txn         (txn),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #21 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin : monitor
        logic b;
        #1;
        if (mon_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL serial_underflow: bit %0d txp=%b appeared, no bit was required", bit_idx, txp);
            end else begin
                b = exp_q.pop_front();
                if (txp !== b || txn !== ~b) begin
                    n_bad++;
                    $display("FAIL serial_bit %0d: txp=%b txn=%b, required txp=%b txn=%b",
                             bit_idx, txp, txn, b, ~b);
                end
            end
            bit_idx++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic land_at(input int m);
        while (cyc < base + m) @(negedge clk);
    endtask

    task automatic exp_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    task automatic exp_idle(input int n);
        repeat (n) exp_q.push_back(1'b0);
    endtask

    task automatic start_lane();
        base    = cyc;
        bit_idx = 0;
        tx_en   = 1'b1;
        mon_en  = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d expected bits left after %0d cycles, required 0", exp_q.size(), budget);
            exp_q.delete();
        end
        mon_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en = 1'b0;
        exp_q.delete();
        rst_n = 1'b0; tx_en = 1'b0; tx_valid = 1'b0; tx_data = '0;
        prbs_mode = 1'b0; clr_err = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (txp !== 1'b0)        begin n_bad++; $display("FAIL reset_txp: got %b, required 0", txp); end
        n_cmp++; if (txn !== 1'b1)        begin n_bad++; $display("FAIL reset_txn: got %b, required 1", txn); end
        n_cmp++; if (tx_ready !== 1'b1)   begin n_bad++; $display("FAIL reset_tx_ready: got %b, required 1", tx_ready); end
        n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
        n_cmp++; if (overflow !== 1'b0)   begin n_bad++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    endtask

    task automatic test_sync_fill();
        do_reset();
        exp_idle(1);
        repeat (4) exp_word(SYNC_W);
        repeat (3) exp_word(FILL_W);
        start_lane();
        wait_drain(80);
        n_cmp++; if (busy !== 1'b1)     begin n_bad++; $display("FAIL sync_busy: got %b, required 1", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL sync_overflow: got %b, required 0", overflow); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        exp_idle(1);
        repeat (4) exp_word(SYNC_W);
        exp_word(FILL_W);
        exp_word(4'h3); exp_word(4'hC); exp_word(4'h5);
        repeat (2) exp_word(FILL_W);
        start_lane();
        land_at(17); tx_valid = 1'b1; tx_data = 4'h3;
        land_at(18); tx_data = 4'hC;
        land_at(19); tx_data = 4'h5;
        land_at(20); tx_valid = 1'b0;
        wait_drain(80);
        n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL b2b_level: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_boundary_push();
        do_reset();
        exp_idle(1);
        repeat (4) exp_word(SYNC_W);
        exp_word(FILL_W);
        exp_word(4'h6);
        exp_word(FILL_W);
        start_lane();
        land_at(16); tx_valid = 1'b1; tx_data = 4'h6;
        land_at(17); tx_valid = 1'b0;
        wait_drain(60);
        n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL bnd_level: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_overflow();
        logic [3:0] vals [9];
        vals = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hE};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tx_valid = 1'b1; tx_data = vals[i];
            step();
            if (i == 7) begin
                n_cmp++; if (tx_ready !== 1'b0)   begin n_bad++; $display("FAIL ovf_ready_full: got %b, required 0", tx_ready); end
                n_cmp++; if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL ovf_level_full: got %0d, required 8", fifo_level); end
                n_cmp++; if (overflow !== 1'b0)   begin n_bad++; $display("FAIL ovf_early: got %b, required 0", overflow); end
            end
        end
        tx_valid = 1'b0;
        n_cmp++; if (overflow !== 1'b1)   begin n_bad++; $display("FAIL ovf_set: got %b, required 1", overflow); end
        n_cmp++; if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL ovf_level_drop: got %0d, required 8", fifo_level); end
        repeat (3) step();
        n_cmp++; if (overflow !== 1'b1)   begin n_bad++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
        tx_valid = 1'b1; tx_data = 4'hD; clr_err = 1'b1;
        step();
        tx_valid = 1'b0;
        n_cmp++; if (overflow !== 1'b1)   begin n_bad++; $display("FAIL ovf_set_wins: got %b, required 1", overflow); end
        step();
        clr_err = 1'b0;
        n_cmp++; if (overflow !== 1'b0)   begin n_bad++; $display("FAIL ovf_clear: got %b, required 0", overflow); end
        exp_idle(1);
        repeat (4) exp_word(SYNC_W);
        for (int i = 0; i < 8; i++) exp_word(vals[i]);
        repeat (2) exp_word(FILL_W);
        start_lane();
        land_at(16); tx_valid = 1'b1; tx_data = 4'hB;
        land_at(17); tx_valid = 1'b0;
        wait_drain(120);
        n_cmp++; if (overflow !== 1'b1)   begin n_bad++; $display("FAIL ovf_full_pop: got %b, required 1", overflow); end
        n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL ovf_drained: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_disable();
        do_reset();
        exp_idle(1);
        repeat (4) exp_word(SYNC_W);
        exp_word(4'hF);
        exp_idle(3);
        start_lane();
        land_at(1); tx_valid = 1'b1; tx_data = 4'hF;
        land_at(2); tx_data = 4'h6;
        land_at(3); tx_data = 4'h9;
        land_at(4); tx_valid = 1'b0;
        land_at(13); tx_en = 1'b0;
        land_at(14); tx_en = 1'b1;
        land_at(18); tx_en = 1'b0;
        wait_drain(60);
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL dis_busy: got %b, required 0", busy); end
        n_cmp++; if (txn !== 1'b1)        begin n_bad++; $display("FAIL dis_txn: got %b, required 1", txn); end
        n_cmp++; if (fifo_level !== 4'd2) begin n_bad++; $display("FAIL dis_retained: got %0d, required 2", fifo_level); end
        exp_idle(1);
        repeat (4) exp_word(SYNC_W);
        exp_word(4'h6); exp_word(4'h9);
        exp_word(FILL_W);
        start_lane();
        wait_drain(80);
        n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL dis_resume_level: got %0d, required 0", fifo_level); end
    endtask

    task automatic test_prbs();
        logic [6:0] r;
        int         want_level;
        do_reset();
        prbs_mode = 1'b1;
        exp_idle(1);
        repeat (4) exp_word(SYNC_W);
`ifdef SERDESPHY_PRBS_EN
        r = 7'h7F;
        for (int i = 0; i < 140; i++) begin
            exp_q.push_back(r[6]);
            r = {r[5:0], r[6] ^ r[5]};
        end
        want_level = 1;
`else
        r = 7'h00;
        exp_word(4'h7);
        repeat (2) exp_word(FILL_W);
        want_level = 0;
`endif
        start_lane();
        land_at(1); tx_valid = 1'b1; tx_data = 4'h7;
        land_at(2); tx_valid = 1'b0;
        wait_drain(200);
        n_cmp++;
        if (fifo_level !== want_level[3:0]) begin
            n_bad++;
            $display("FAIL prbs_level: got %0d, required %0d (lfsr %h)", fifo_level, want_level, r);
        end
        prbs_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        base  = cyc;
        tx_en = 1'b1;
        land_at(1); tx_valid = 1'b1; tx_data = 4'h1;
        land_at(2); tx_data = 4'h2;
        land_at(3); tx_data = 4'h3;
        land_at(4); tx_valid = 1'b0;
        n_cmp++; if (txp !== 1'b1)        begin n_bad++; $display("FAIL rmid_pre_txp: got %b, required 1", txp); end
        n_cmp++; if (fifo_level !== 4'd3) begin n_bad++; $display("FAIL rmid_pre_level: got %0d, required 3", fifo_level); end
        #5;
        rst_n = 1'b0;
        tx_en = 1'b0;
        #1;
        n_cmp++; if (txp !== 1'b0)        begin n_bad++; $display("FAIL rmid_txp: got %b, required 0", txp); end
        n_cmp++; if (txn !== 1'b1)        begin n_bad++; $display("FAIL rmid_txn: got %b, required 1", txn); end
        n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL rmid_level: got %0d, required 0", fifo_level); end
        n_cmp++; if (tx_ready !== 1'b1)   begin n_bad++; $display("FAIL rmid_ready: got %b, required 1", tx_ready); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rmid_busy: got %b, required 0", busy); end
        step();
        rst_n = 1'b1;
        step(); step();
        n_cmp++; if (txp !== 1'b0)        begin n_bad++; $display("FAIL rmid_after_txp: got %b, required 0", txp); end
    endtask

    initial begin
        test_reset();
        test_sync_fill();
        test_back_to_back();
        test_boundary_push();
        test_overflow();
        test_disable();
        test_prbs();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
